atm_disp_sched: RTL and testbench
=================================

// Module: atm_disp_sched
// PURPOSE
//   Display scheduler for the ATM front panel. Selects one of NUM_SRC 16-bit value sources
//   (page), converts it to BCD sequentially and time-multiplexes 8 seven-segment digits.
//   Page follows the ATM FSM state and is stepped manually by the debounced up button.
//   Sits between the ATM FSM / value registers and the board AN/led pins.
// PARAMETERS
//   NUM_SRC       5        number of value sources (pages), 2..8
//   SCAN_DIV      100000   clk cycles per digit slot (1 kHz digit rate at 100 MHz)
//   DEBOUNCE_CYC  1000000  cycles btn_up must be stable before a level is accepted (10 ms)
// PORTS
//   clk        in   1              system clock
//   rst_n      in   1              synchronous reset, active-low
//   btn_up     in   1              raw BTNU, asynchronous to clk
//   cur_state  in   16             ATM FSM current state code
//   src_bus    in   16*NUM_SRC     packed sources; page k = src_bus[16k+15:16k]
//   AN         out  8              digit anodes, one-hot active-low
//   led        out  7              segments {g,f,e,d,c,b,a}, active-low
//   page       out  3              current page index, 0..NUM_SRC-1
//   busy       out  1              high while a BCD conversion is in progress
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge): page=0, AN=8'hFF, led=7'h7F, busy=0, digit idx=0,
//     display reg=0, disp_valid=0, conv FSM=IDLE, debounce counter=0.
//     Reset mid-conversion aborts it; no partial result reaches the display reg.
//   Button: 2-flop sync; a level change is accepted after DEBOUNCE_CYC consecutive stable
//     cycles; an accepted 0->1 gives a 1-cycle press pulse. Shorter glitches are ignored.
//   Page: press -> page+1, wrapping NUM_SRC-1 -> 0. cur_state differing from its registered
//     previous value -> page = cur_state[2:0] if < NUM_SRC, else 0. Same-cycle state change
//     and press: state change wins; the press is dropped.
//   Conversion FSM IDLE -> LOAD -> SHIFT(x16) -> DONE -> IDLE:
//     IDLE->LOAD when !disp_valid, or selected source != last converted value, or page changed.
//     LOAD latches the selected value; SHIFT does 16 double-dabble iterations (add 3 to any
//     nibble >=5, then shift left); DONE writes 5 BCD digits atomically to the display reg
//     and sets disp_valid. Latency LOAD->display reg updated = 18 cycles. busy=1 in LOAD..DONE.
//     Source or page changes during SHIFT are ignored until DONE; the IDLE compare then
//     restarts. Range 0..65535 always fits in 5 digits.
//   Scan: counter 0..SCAN_DIV-1; at wrap, digit idx advances 0..7 and wraps 7->0.
//     AN[idx]=0, others 1; AN/led are registered, updated together.
//     idx 0..4 = BCD digits (idx0 least significant); idx5 blank; idx6 = page+1; idx7 = 'P'.
//     Blank = 7'h7F; 'P' = 7'h0C; decimal digits use the standard active-low code table.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: leading zeros in idx4..1 show blank; idx0 always shown
//     (value 0 -> single '0'). Undefined: all 5 BCD digits shown, zero-padded.
// STRUCTURE
//   Package atm_disp_pkg: conv FSM state encodings, SEG_BLANK, SEG_P, BCD->segment function.
//   Sub-module bin2bcd_seq: start/done handshake, 16-bit in, 20-bit BCD out; owns
//     LOAD/SHIFT/DONE. Debounce, page logic and scan stay in the top.
// TESTING (bench uses SCAN_DIV=4, DEBOUNCE_CYC=8, NUM_SRC=5, src = 7777,1111,22,333,4444)
//   Reset release -> within 20 cycles disp reg = 07777; scan shows AN=8'hFE with '7',
//     AN=8'hEF '0', AN=8'hBF '1', AN=8'h7F 'P'.
//   btn_up high 12 cycles -> page=1, display 01111; 5-cycle pulse -> no page change.
//   Page 4 + one accepted press -> page=0, display returns to 07777.
//   cur_state 0->2 in same cycle as press pulse -> page=2, display 00022.
//   src page0 7777->9999 at SHIFT iteration 5 -> disp reg shows 07777 then 09999,
//     never an intermediate value; busy high for 2 back-to-back conversions.
//   src=65535 -> 65535; src=0 -> 00000; with LEADING_ZERO_BLANK_EN, 22 shows blank x3,'2','2'.

Source files
------------

// File: rtl/atm_disp_pkg.sv
// Shared definitions for the ATM front-panel display scheduler.
//   conv_state_e : states of the sequential binary-to-BCD converter
//   SEG_BLANK    : all segments off (active-low)
//   SEG_P        : letter 'P' (active-low)
//   bcd2seg()    : decimal digit -> active-low {g,f,e,d,c,b,a} pattern
package atm_disp_pkg;

   typedef enum logic [1:0] {
      CONV_IDLE  = 2'd0,
      CONV_LOAD  = 2'd1,
      CONV_SHIFT = 2'd2,
      CONV_DONE  = 2'd3
   } conv_state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_P     = 7'h0C;

   function automatic logic [6:0] bcd2seg(input logic [3:0] d);
      case (d)
         4'd0:    bcd2seg = 7'h40;
         4'd1:    bcd2seg = 7'h79;
         4'd2:    bcd2seg = 7'h24;
         4'd3:    bcd2seg = 7'h30;
         4'd4:    bcd2seg = 7'h19;
         4'd5:    bcd2seg = 7'h12;
         4'd6:    bcd2seg = 7'h02;
         4'd7:    bcd2seg = 7'h78;
         4'd8:    bcd2seg = 7'h00;
         4'd9:    bcd2seg = 7'h10;
         default: bcd2seg = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/atm_disp_sched_bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter (double dabble).
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : request a conversion (accepted only while idle)
//   bin_in     : value, sampled in the LOAD cycle (not at start)
//   busy       : high in LOAD, SHIFT and DONE
//   load       : high in the LOAD cycle, lets the caller record what was sampled
//   done       : one-cycle strobe, bcd is valid only while it is high
//   bcd        : 5 BCD digits, digit 0 in bcd[3:0]
module bin2bcd_seq
   import atm_disp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] bin_in,
   output logic        busy,
   output logic        load,
   output logic        done,
   output logic [19:0] bcd
);

   conv_state_e state_q, state_d;
   logic [35:0] sh_q, sh_d;   // {bcd[19:0], binary[15:0]}
   logic [3:0]  it_q, it_d;
   logic [35:0] adj;

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      it_d    = it_q;
      adj     = sh_q;
      case (state_q)
         CONV_IDLE: if (start) state_d = CONV_LOAD;
         CONV_LOAD: begin
            sh_d    = {20'd0, bin_in};
            it_d    = 4'd0;
            state_d = CONV_SHIFT;
         end
         CONV_SHIFT: begin
            for (int n = 0; n < 5; n++)
               if (adj[16+4*n +: 4] >= 4'd5)
                  adj[16+4*n +: 4] = adj[16+4*n +: 4] + 4'd3;
            sh_d = {adj[34:0], 1'b0};
            it_d = it_q + 4'd1;
            if (it_q == 4'd15) state_d = CONV_DONE;
         end
         CONV_DONE: state_d = CONV_IDLE;
         default:   state_d = CONV_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= CONV_IDLE;
         sh_q    <= '0;
         it_q    <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         it_q    <= it_d;
      end
   end

   assign busy = (state_q != CONV_IDLE);
   assign load = (state_q == CONV_LOAD);
   assign done = (state_q == CONV_DONE);
   assign bcd  = sh_q[35:16];

endmodule

// File: rtl/atm_disp_sched.sv
// ATM front-panel display scheduler: picks a 16-bit source (page), converts
// it to BCD and multiplexes 8 seven-segment digits.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zeros in digits 4..1).
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   btn_up     : raw up button (asynchronous), steps the page
//   cur_state  : ATM FSM state; any change reloads the page from cur_state[2:0]
//   src_bus    : NUM_SRC packed 16-bit sources, page k at [16k+15:16k]
//   AN, led    : active-low anodes (one-hot) and segments {g,f,e,d,c,b,a}
//   page       : current page 0..NUM_SRC-1
//   busy       : BCD conversion in progress
module atm_disp_sched
   import atm_disp_pkg::*;
#(
   parameter int NUM_SRC      = 5,
   parameter int SCAN_DIV     = 100000,
   parameter int DEBOUNCE_CYC = 1000000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  btn_up,
   input  logic [15:0]           cur_state,
   input  logic [16*NUM_SRC-1:0] src_bus,
   output logic [7:0]            AN,
   output logic [6:0]            led,
   output logic [2:0]            page,
   output logic                  busy
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYC - 1);

   logic          sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic [15:0]   prev_state_q, prev_state_d;
   logic [2:0]    page_q, page_d, cv_page_q, cv_page_d, idx_q, idx_d;
   logic [15:0]   cv_val_q, cv_val_d, src_sel;
   logic [19:0]   disp_q, disp_d, upper;
   logic          disp_valid_q, disp_valid_d;
   logic [SW-1:0] scan_q, scan_d;
   logic [7:0]    an_q, an_d;
   logic [6:0]    led_q, led_d;
   logic          accept, press, start, cv_busy, cv_load, cv_done;
   logic [19:0]   cv_bcd;

   bin2bcd_seq u_conv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .bin_in (src_sel),
      .busy   (cv_busy),
      .load   (cv_load),
      .done   (cv_done),
      .bcd    (cv_bcd)
   );

   always_comb begin
      sync1_d      = btn_up;
      sync2_d      = sync1_q;
      deb_d        = deb_q;
      dcnt_d       = '0;
      prev_state_d = cur_state;
      page_d       = page_q;
      cv_val_d     = cv_val_q;
      cv_page_d    = cv_page_q;
      disp_d       = disp_q;
      disp_valid_d = disp_valid_q;
      scan_d       = scan_q + SW'(1);
      idx_d        = idx_q;
      src_sel      = '0;
      led_d        = SEG_BLANK;

      // Debounce: the level is taken once it has differed for DEBOUNCE_CYC cycles.
      accept = (sync2_q != deb_q) && (dcnt_q == DMAX);
      press  = accept && sync2_q;
      if (sync2_q != deb_q) begin
         if (accept) deb_d  = sync2_q;
         else        dcnt_d = dcnt_q + DW'(1);
      end

      // A state change overrides a simultaneous press.
      if (cur_state != prev_state_q)
         page_d = ({1'b0, cur_state[2:0]} < 4'(NUM_SRC)) ? cur_state[2:0] : 3'd0;
      else if (press)
         page_d = (page_q == 3'(NUM_SRC - 1)) ? 3'd0 : page_q + 3'd1;

      for (int k = 0; k < NUM_SRC; k++)
         if (page_q == 3'(k)) src_sel = src_bus[16*k +: 16];

      start = !cv_busy && (!disp_valid_q || src_sel != cv_val_q || page_q != cv_page_q);

      // Remember exactly what the converter sampled, for the restart compare.
      if (cv_load) begin
         cv_val_d  = src_sel;
         cv_page_d = page_q;
      end
      if (cv_done) begin
         disp_d       = cv_bcd;
         disp_valid_d = 1'b1;
      end

      if (scan_q == SMAX) begin
         scan_d = '0;
         idx_d  = idx_q + 3'd1;
      end

      an_d  = ~(8'd1 << idx_q);
      upper = disp_q >> {idx_q, 2'b00};
      case (idx_q)
         3'd5: led_d = SEG_BLANK;
         3'd6: led_d = bcd2seg({1'b0, page_q} + 4'd1);
         3'd7: led_d = SEG_P;
         default: begin
`ifdef LEADING_ZERO_BLANK_EN
            if (idx_q != 3'd0 && upper == 20'd0) led_d = SEG_BLANK;
            else                                 led_d = bcd2seg(upper[3:0]);
`else
            led_d = bcd2seg(upper[3:0]);
`endif
         end
      endcase
   end

   always_ff @(posedge clk) begin
      prev_state_q <= prev_state_d;
      if (!rst_n) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         deb_q        <= 1'b0;
         dcnt_q       <= '0;
         page_q       <= '0;
         cv_val_q     <= '0;
         cv_page_q    <= '0;
         disp_q       <= '0;
         disp_valid_q <= 1'b0;
         scan_q       <= '0;
         idx_q        <= '0;
         an_q         <= 8'hFF;
         led_q        <= SEG_BLANK;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         deb_q        <= deb_d;
         dcnt_q       <= dcnt_d;
         page_q       <= page_d;
         cv_val_q     <= cv_val_d;
         cv_page_q    <= cv_page_d;
         disp_q       <= disp_d;
         disp_valid_q <= disp_valid_d;
         scan_q       <= scan_d;
         idx_q        <= idx_d;
         an_q         <= an_d;
         led_q        <= led_d;
      end
   end

   assign AN   = an_q;
   assign led  = led_q;
   assign page = page_q;
   assign busy = cv_busy;

endmodule

// File: tb/tb_atm_disp_sched.sv
// Bench for atm_disp_sched (SCAN_DIV=4, DEBOUNCE_CYC=8, NUM_SRC=5).
module tb_atm_disp_sched;
   localparam int NS = 5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            btn_up = 1'b0;
   logic [15:0]     cur_state = 16'd0;
   logic [16*NS-1:0] src_bus = '0;
   logic [7:0]      AN;
   logic [6:0]      led;
   logic [2:0]      page;
   logic            busy;

   int errs = 0;
   int checks = 0;

   atm_disp_sched #(.NUM_SRC(NS), .SCAN_DIV(4), .DEBOUNCE_CYC(8)) dut (
      .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .cur_state(cur_state),
      .src_bus(src_bus), .AN(AN), .led(led), .page(page), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic [15:0] val;
      logic [19:0] bcd;
   } vec_t;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
         4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
         4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
         4'd9: return 7'h10;  default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [19:0] to_bcd(input int v);
      logic [19:0] r;
      int x;
      x = v;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [55:0] exp_segs(input logic [19:0] bcd, input int pg);
      logic [7:0][6:0] e;
      for (int i = 0; i < 5; i++) begin
         e[i] = seg_of(bcd[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
         if (i > 0 && (bcd >> (4*i)) == 20'd0) e[i] = 7'h7F;
`endif
      end
      e[5] = 7'h7F;
      e[6] = seg_of(4'(pg + 1));
      e[7] = 7'h0C;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic set_src(input int k, input logic [15:0] v);
      src_bus[16*k +: 16] = v;
   endtask

   // Wait until any triggered conversion has finished (bounded).
   task automatic settle();
      int quiet;
      quiet = 0;
      repeat (2) @(negedge clk);
      for (int c = 0; c < 200 && quiet < 3; c++) begin
         @(negedge clk);
         quiet = busy ? 0 : quiet + 1;
      end
      if (quiet < 3) begin
         checks++; errs++;
         $display("FAIL settle: busy still %0b after 200 cycles", busy);
      end
   endtask

   task automatic read_scan(output logic [55:0] got, output bit ok);
      logic [7:0][6:0] g;
      logic [7:0] seen;
      g = '0; seen = '0;
      @(negedge clk);
      for (int c = 0; c < 48 && seen != 8'hFF; c++) begin
         @(negedge clk);
         for (int i = 0; i < 8; i++)
            if (AN == ~(8'd1 << i)) begin g[i] = led; seen[i] = 1'b1; end
      end
      got = g;
      ok = (seen == 8'hFF);
   endtask

   task automatic check_disp(input string nm, input logic [19:0] bcd, input int pg);
      logic [55:0] g;
      bit ok;
      settle();
      chk({nm, "_page"}, 64'(page), 64'(pg));
      read_scan(g, ok);
      if (!ok) begin
         checks++; errs++;
         $display("FAIL %s_scan: not all 8 anodes seen, AN=%h", nm, AN);
      end else
         chk(nm, 64'(g), 64'(exp_segs(bcd, pg)));
   endtask

   task automatic press(input int n);
      btn_up = 1'b1;
      repeat (n) @(negedge clk);
      btn_up = 1'b0;
      repeat (14) @(negedge clk);
   endtask

   initial begin
      vec_t tbl[6];
      bit trace[64];
      int fall, t0, runs, len1, len2, m_page, r, s;
      bit seen_b, bad;
      logic [15:0] m_src[NS];
      logic [15:0] m_prev;

      tbl = '{'{16'd0,     20'h00000}, '{16'd65535, 20'h65535},
              '{16'd22,    20'h00022}, '{16'd9,     20'h00009},
              '{16'd10010, 20'h10010}, '{16'd40960, 20'h40960}};

      set_src(0, 16'd7777); set_src(1, 16'd1111); set_src(2, 16'd22);
      set_src(3, 16'd333);  set_src(4, 16'd4444);

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_AN", 64'(AN), 64'h FF);
      chk("rst_led", 64'(led), 64'h7F);
      chk("rst_page", 64'(page), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;

      // first conversion completes within 20 cycles of release
      fall = -1; seen_b = 0;
      for (int k = 1; k <= 30 && fall < 0; k++) begin
         @(negedge clk);
         if (busy) seen_b = 1;
         else if (seen_b) fall = k;
      end
      checks++;
      if (fall < 0 || fall > 20) begin
         errs++;
         $display("FAIL first_conv: done at cycle %0d, required <= 20", fall);
      end
      check_disp("init", 20'h07777, 0);

      // debounced press, then a glitch that must be ignored
      press(12);
      check_disp("btn_press", 20'h01111, 1);
      press(5);
      chk("glitch_page", 64'(page), 64'd1);

      // state-driven page and wrap on press
      cur_state = 16'd4;
      check_disp("state4", 20'h04444, 4);
      press(12);
      check_disp("wrap", 20'h07777, 0);
      cur_state = 16'd0;
      repeat (3) @(negedge clk);

      // state change in the same cycle as the press pulse: state wins
      btn_up = 1'b1;
      repeat (9) @(posedge clk);
      @(negedge clk);
      cur_state = 16'd2;
      repeat (4) @(negedge clk);
      btn_up = 1'b0;
      repeat (14) @(negedge clk);
      check_disp("collide", 20'h00022, 2);

      // source change during SHIFT: two whole conversions, no intermediate digits
      cur_state = 16'd0;
      t0 = -1;
      for (int k = 0; k < 10 && t0 < 0; k++) begin
         @(negedge clk);
         if (busy) t0 = k;
      end
      chk("midshift_start", 64'(t0 >= 0), 64'd1);
      bad = 0;
      for (int k = 0; k < 64; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 5) set_src(0, 16'd9999);
         trace[k] = busy;
         for (int i = 0; i < 4; i++)
            if (AN == ~(8'd1 << i) && !(led == seg_of(4'd0) || led == seg_of(4'd2) ||
                                        led == seg_of(4'd7) || led == seg_of(4'd9))) bad = 1;
      end
      runs = 0; len1 = 0; len2 = 0;
      for (int k = 0; k < 64; k++) begin
         if (trace[k] && (k == 0 || !trace[k-1])) runs++;
         if (trace[k] && runs == 1) len1++;
         if (trace[k] && runs == 2) len2++;
      end
      chk("midshift_runs", 64'(runs), 64'd2);
      chk("midshift_len1", 64'(len1), 64'd18);
      chk("midshift_len2", 64'(len2), 64'd18);
      chk("midshift_digits", 64'(bad), 64'd0);
      check_disp("midshift_final", 20'h09999, 0);

      // table of conversion vectors on page 0
      for (int i = 0; i < 6; i++) begin
         set_src(0, tbl[i].val);
         check_disp($sformatf("vec%0d", i), tbl[i].bcd, 0);
      end

      // randomized sources, state changes and presses against a page model
      m_page = 0;
      m_prev = cur_state;
      for (int it = 0; it < 10; it++) begin
         for (int k = 0; k < NS; k++) begin
            m_src[k] = 16'($urandom_range(0, 65535));
            set_src(k, m_src[k]);
         end
         r = int'($urandom_range(0, 2));
         if (r == 0) begin
            s = int'($urandom_range(0, 7));
            cur_state = 16'(s);
            if (16'(s) != m_prev) m_page = (s < NS) ? s : 0;
            m_prev = 16'(s);
         end else if (r == 1) begin
            press(12);
            m_page = (m_page + 1) % NS;
         end
         check_disp($sformatf("rand%0d", it), to_bcd(int'(m_src[m_page])), m_page);
      end

      // reset in the middle of a conversion
      @(negedge clk);
      set_src(0, 16'd12345);
      cur_state = 16'd0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_AN", 64'(AN), 64'hFF);
      rst_n = 1'b1;
      check_disp("post_rst", 20'h12345, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
